// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - FSM state encodings (state_t)
//   - opcode constants for the supported instructions
//   - ALUOp / ALUSrcB / RegDst / PCSource field encodings
//   - ctrl_t: the packed control word handed from the decoder to the top
//   - dispatch(): DECODE-state opcode -> next state mapping
// Build option: MULTICYCLE_JAL_EN adds the jal instruction (state S_JAL).
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JAL      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Next state out of DECODE. S_FETCH doubles as the "unsupported opcode"
    // answer, which the decoder uses to raise illegal_op.
    function automatic state_t dispatch(input logic [5:0] opcode);
        state_t nxt;
        case (opcode)
            OP_R:    nxt = S_EXECUTE;
            OP_LW:   nxt = S_MEMADR;
            OP_SW:   nxt = S_MEMADR;
            OP_BEQ:  nxt = S_BRANCH;
            OP_J:    nxt = S_JUMP;
            OP_ADDI: nxt = S_ADDIEXEC;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL:  nxt = S_JAL;
`endif
            default: nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// ----------------------------------------------------------------------------
// multicycle_control_decode
// Combinational state -> control word decoder. The word is the raw Moore
// output of each state; FETCH's IRWrite/PCWrite are emitted unconditionally
// here and qualified by mem_ready in the top.
// Ports:
//   state  in   current FSM state
//   op     in   IR opcode (only looked at in DECODE, for illegal_op)
//   ctrl   out  packed control word
// Build option: MULTICYCLE_JAL_EN decodes S_JAL; otherwise S_JAL falls into
// the undefined-state default (all zero).
// ----------------------------------------------------------------------------
module multicycle_control_decode
    import multicycle_control_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = (dispatch(op) == S_FETCH);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = REGDST_RD;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_dst   = REGDST_RT;
                ctrl.reg_write = 1'b1;
            end
`ifdef MULTICYCLE_JAL_EN
            S_JAL: begin
                // Datapath routes PC to the write data when RegDst selects $31.
                ctrl.reg_dst   = REGDST_RA;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing the multi-cycle MIPS datapath (shared ALU, unified
// memory, IR/MDR/A/B/ALUOut). Stalls in FETCH/MEMREAD/MEMWRITE until
// mem_ready.
// Ports:
//   clk, reset (sync, active-high)
//   op          in   IR[31:26], sampled in DECODE and MEMADR only
//   mem_ready   in   memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst[1:0], RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[2:0], PCSource[1:0]
//               out  datapath controls
//   illegal_op  out  pulse in DECODE for an unsupported opcode
//   state_o     out  current state (debug)
// Build option: define MULTICYCLE_JAL_EN to support jal (op 000011).
// ----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic [1:0]      RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            illegal_op,
    output logic [ST_W-1:0] state_o
);

    state_t state_reg;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
                S_DECODE:   state_reg <= dispatch(op);
                S_MEMADR: begin
                    if (op == OP_LW)      state_reg <= S_MEMREAD;
                    else if (op == OP_SW) state_reg <= S_MEMWRITE;
                    else                  state_reg <= S_FETCH;
                end
                S_MEMREAD:  if (mem_ready) state_reg <= S_MEMWB;
                S_MEMWB:    state_reg <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state_reg <= S_FETCH;
                S_EXECUTE:  state_reg <= S_ALUWB;
                S_ALUWB:    state_reg <= S_FETCH;
                S_BRANCH:   state_reg <= S_FETCH;
                S_JUMP:     state_reg <= S_FETCH;
                S_ADDIEXEC: state_reg <= S_ADDIWB;
                S_ADDIWB:   state_reg <= S_FETCH;
`ifdef MULTICYCLE_JAL_EN
                S_JAL:      state_reg <= S_FETCH;
`endif
                default:    state_reg <= S_FETCH;
            endcase
        end
    end

    multicycle_control_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .state (state_reg),
        .op    (op),
        .ctrl  (ctrl_raw)
    );

    // The instruction fetch only commits (IR load, PC+4) once memory answers.
    // Reset blanks everything combinationally so nothing writes in that cycle.
    always_comb begin
        ctrl_out = ctrl_raw;
        if (state_reg == S_FETCH && !mem_ready) begin
            ctrl_out.ir_write = 1'b0;
            ctrl_out.pc_write = 1'b0;
        end
        if (reset) begin
            ctrl_out = CTRL_IDLE;
        end
    end

    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign IorD        = ctrl_out.iord;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign IRWrite     = ctrl_out.ir_write;
    assign MemtoReg    = ctrl_out.mem_to_reg;
    assign RegDst      = ctrl_out.reg_dst;
    assign RegWrite    = ctrl_out.reg_write;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ALUOp       = ctrl_out.alu_op;
    assign PCSource    = ctrl_out.pc_source;
    assign illegal_op  = ctrl_out.illegal_op;
    assign state_o     = reset ? ST_W'(S_FETCH) : ST_W'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control. The reference builds the
// expected state trace of each instruction from its class (plus stall
// cycles) and derives per-state outputs from the control table.
// Honours MULTICYCLE_JAL_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] RegDst, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    int exp_st[$];
    bit exp_rdy[$];

    logic [18:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    multicycle_control #(.OP_W(6), .ST_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] o);
        bit ok;
        ok = (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
             (o == 6'b000100) || (o == 6'b000010) || (o == 6'b001000);
`ifdef MULTICYCLE_JAL_EN
        ok = ok || (o == 6'b000011);
`endif
        return ok;
    endfunction

    // Control table: outputs for a given state number.
    function automatic logic [18:0] exp_out(input int st, input bit rdy, input logic [5:0] o);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
        logic rw = 0, asa = 0, ill = 0;
        logic [1:0] rd = 0, asb = 0, pcs = 0;
        logic [2:0] aop = 0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; ill = !legal(o); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin iord = 1; mr = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 3'b010; end
            7:  begin rd = 2'b01; rw = 1; end
            8:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            12: begin rd = 2'b10; pcw = 1; pcs = 2'b10; rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    task automatic push(input int st, input bit r);
        exp_st.push_back(st);
        exp_rdy.push_back(r);
    endtask

    // Expected trace of one instruction from FETCH up to (not incl.) the next FETCH.
    task automatic build_seq(input logic [5:0] o, input int fst, input int mst);
        exp_st.delete();
        exp_rdy.delete();
        repeat (fst) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom_range(0, 1)));
        if (o == 6'b100011) begin
            push(2, 1'($urandom_range(0, 1)));
            repeat (mst) push(3, 1'b0);
            push(3, 1'b1);
            push(4, 1'($urandom_range(0, 1)));
        end else if (o == 6'b101011) begin
            push(2, 1'($urandom_range(0, 1)));
            repeat (mst) push(5, 1'b0);
            push(5, 1'b1);
        end else if (o == 6'b000000) begin
            push(6, 1'($urandom_range(0, 1)));
            push(7, 1'($urandom_range(0, 1)));
        end else if (o == 6'b000100) begin
            push(8, 1'($urandom_range(0, 1)));
        end else if (o == 6'b000010) begin
            push(9, 1'($urandom_range(0, 1)));
        end else if (o == 6'b001000) begin
            push(10, 1'($urandom_range(0, 1)));
            push(11, 1'($urandom_range(0, 1)));
        end else if (legal(o)) begin
            push(12, 1'($urandom_range(0, 1)));
        end
    endtask

    // Runs one instruction; entered just after a negedge with the DUT in FETCH.
    task automatic test_instr(input logic [5:0] o, input int fst, input int mst);
        logic [18:0] e;
        build_seq(o, fst, mst);
        for (int i = 0; i < exp_st.size(); i++) begin
            mem_ready = exp_rdy[i];
            op = (exp_st[i] == 0) ? 6'($urandom) : o;
            #1;
            e = exp_out(exp_st[i], exp_rdy[i], o);
            total++;
            if (state_o !== 4'(exp_st[i])) begin
                bad++;
                $display("FAIL instr_state op=%b cyc=%0d got=%0d want=%0d", o, i, state_o, exp_st[i]);
            end
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL instr_ctrl op=%b cyc=%0d got=%b want=%b", o, i, obs, e);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL instr_return op=%b got=%0d want=0", o, state_o);
        end
        $display("instr op=%b fetch_stall=%0d mem_stall=%0d cycles=%0d", o, fst, mst, exp_st.size());
    endtask

    task automatic test_reset;
        // Walk lw into MEMREAD, then reset there.
        reset = 1'b0; mem_ready = 1'b1; op = 6'b100011;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (state_o !== 4'd3) begin
            bad++;
            $display("FAIL reset_pre got=%0d want=3", state_o);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== 19'd0 || state_o !== 4'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b/%0d want=0/0", i, obs, state_o);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        total++;
        if (state_o !== 4'd0 || MemRead !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got=%0d/%b want=0/1", state_o, MemRead);
        end
        $display("reset mid-MEMREAD done");
    endtask

    task automatic test_fetch_stall;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op = 6'($urandom);
            #1;
            total++;
            if (IRWrite !== 1'b0 || PCWrite !== 1'b0 || state_o !== 4'd0) begin
                bad++;
                $display("FAIL fetch_stall cyc=%0d got=%b%b/%0d want=00/0", i, IRWrite, PCWrite, state_o);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            bad++;
            $display("FAIL fetch_ready got=%b%b want=11", IRWrite, PCWrite);
        end
        @(negedge clk);
        op = 6'b000010;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL fetch_stall_end got=%0d want=0", state_o);
        end
        $display("fetch stall 4 cycles done");
    endtask

    task automatic test_back_to_back;
        logic [5:0]  ops[3]  = '{6'b000000, 6'b000100, 6'b000010};
        int          lats[3] = '{4, 3, 3};
        logic [18:0] last;
        int          cnt;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            cnt = 0;
            last = '0;
            do begin
                last = obs;
                @(negedge clk);
                #1;
                cnt++;
            end while (state_o !== 4'd0 && cnt < 20);
            total++;
            if (cnt !== lats[k]) begin
                bad++;
                $display("FAIL b2b_latency op=%b got=%0d want=%0d", ops[k], cnt, lats[k]);
            end
            total++;
            if (last !== exp_out(k == 0 ? 7 : (k == 1 ? 8 : 9), 1'b1, ops[k])) begin
                bad++;
                $display("FAIL b2b_last_ctrl op=%b got=%b", ops[k], last);
            end
            $display("b2b op=%b cycles=%0d", ops[k], cnt);
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; op = 6'd0;
        @(negedge clk);
        #1;
        total++;
        if (obs !== 19'd0 || state_o !== 4'd0) begin
            bad++;
            $display("FAIL power_on_reset got=%b/%0d want=0/0", obs, state_o);
        end
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_instr(6'b100011, 0, 0);           // lw
        test_instr(6'b101011, 0, 2);           // sw, 2 stall cycles
        test_back_to_back();
        test_fetch_stall();
        test_instr(6'b111111, 0, 0);           // illegal
        test_instr(6'b000011, 0, 0);           // jal or illegal depending on build
        test_instr(6'b001000, 1, 0);           // addi
        for (int n = 0; n < 40; n++) begin
            logic [5:0] pick[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                    6'b000010, 6'b001000, 6'b000011, 6'b111111};
            logic [5:0] o;
            o = pick[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            test_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
